// File: rtl/canny_pkg.sv
// Shared type definitions for the Canny edge pipeline stages.
// Contents:
//   edge_class_t - per-pixel classification emitted toward hysteresis
//   grad_dir_t   - quantised gradient direction from gradient_calculation
//   nms_state_t  - frame sequencing state of the NMS/threshold stage
package canny_pkg;

   typedef enum logic [1:0] {
      EDGE_NONE   = 2'd0,
      EDGE_WEAK   = 2'd1,
      EDGE_STRONG = 2'd2
   } edge_class_t;

   typedef enum logic [1:0] {
      DIR_0   = 2'd0,
      DIR_45  = 2'd1,
      DIR_90  = 2'd2,
      DIR_135 = 2'd3
   } grad_dir_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } nms_state_t;

endpackage

// File: rtl/nms_line_buffer.sv
// Single-row line buffer for the NMS window.
// One write and one read per cycle, both at the same address; the read is
// combinational from the array, so it returns the entry written a full row
// earlier (old data) while the new entry is stored on the clock edge.
// Ports:
//   clk     - clock
//   wr_en   - store wr_data at addr on this edge
//   addr    - shared read/write column address
//   wr_data - entry to store
//   rd_data - entry currently stored at addr
module nms_line_buffer #(
   parameter int DEPTH = 512,
   parameter int WIDTH = 13,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

   assign rd_data = mem[addr];

endmodule

// File: rtl/nms_stream_classifier.sv
// Streaming non-maximum suppression plus double-threshold classification.
// Accepts one raster-order gradient sample per valid cycle, builds a 3x3
// window from two internal line buffers and emits one classified output per
// input pixel, flushing the last IMG_W+1 (border) outputs on its own.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   mag_in, dir_in      - gradient magnitude / quantised direction
//   in_valid            - sample present (no backpressure)
//   thr_low, thr_high   - thresholds, latched on the first pixel of a frame
//   edge_mag            - retained magnitude, 0 when suppressed/below thr_low
//   edge_class          - 0 none, 1 weak, 2 strong
//   out_valid, out_eof  - output strobe, last pixel of frame
//   busy                - frame in progress
//   err                 - sticky: input arrived during FLUSH
//
// state | meaning
// IDLE  | waiting for the first pixel of a frame
// RUN   | accepting pixels, one output per accepted pixel after the first IMG_W+1
// FLUSH | input done, emitting the trailing IMG_W+1 border outputs
module nms_stream_classifier
   import canny_pkg::*;
#(
   parameter int IMG_W = 512,
   parameter int IMG_H = 512,
   parameter int MAG_W = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [MAG_W-1:0] mag_in,
   input  logic [1:0]       dir_in,
   input  logic             in_valid,
   input  logic [MAG_W-1:0] thr_low,
   input  logic [MAG_W-1:0] thr_high,
   output logic [MAG_W-1:0] edge_mag,
   output logic [1:0]       edge_class,
   output logic             out_valid,
   output logic             out_eof,
   output logic             busy,
   output logic             err
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int FW = $clog2(IMG_W + 3);
   localparam int PW = MAG_W + 2;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);
   localparam logic [FW-1:0] FLUSH_LOAD = FW'(IMG_W + 2);
   localparam logic [FW-1:0] FLUSH_TWO  = FW'(2);

   nms_state_t state_q, state_d;

   logic [CW-1:0]    col_q;
   logic [RW-1:0]    row_q;
   logic [FW-1:0]    flush_cnt;
   logic             accept;
   logic             last_pix;
   logic             flush_issue;
   logic             flush_last;

   logic [MAG_W-1:0] thr_low_q, thr_high_q;

   logic [PW-1:0]    pix_in, lb1_rd, lb2_rd;

   // window columns: *_w = column c-2, *_c = column c-1; column c is live
   logic [MAG_W-1:0] top_w, top_c, mid_w, mid_c, bot_w, bot_c;
   grad_dir_t        mid_c_dir;
   logic [MAG_W-1:0] top_e, mid_e, bot_e;
   logic [MAG_W-1:0] nb_a, nb_b;
   logic             keep;
   logic             emit;
   logic             border;
   logic [1:0]       unused_top_dir;

   logic             s1_valid, s1_eof, s1_keep;
   logic [MAG_W-1:0] s1_mag;

   assign accept   = in_valid && (state_q != FLUSH);
   assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
   assign busy     = (state_q != IDLE);

   // FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      flush_issue = 1'b0;
      flush_last  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (in_valid && last_pix) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            // counter runs IMG_W+2 .. 0: issues while >= 2, the last two
            // ticks let the final output drain through the pipeline
            flush_issue = (flush_cnt >= FLUSH_TWO);
            flush_last  = (flush_cnt == FLUSH_TWO);
            if (flush_cnt == '0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flush_cnt <= '0;
      end else if ((state_q != FLUSH) && (state_d == FLUSH)) begin
         flush_cnt <= FLUSH_LOAD;
      end else if ((state_q == FLUSH) && (flush_cnt != '0)) begin
         flush_cnt <= flush_cnt - FW'(1);
      end
   end

   // raster position of the incoming pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else if (accept) begin
         if (col_q == COL_LAST) begin
            col_q <= '0;
            row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
         end else begin
            col_q <= col_q + COL_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         thr_low_q  <= '0;
         thr_high_q <= '0;
         err        <= 1'b0;
      end else begin
         if ((state_q == IDLE) && in_valid) begin
            thr_high_q <= thr_high;
            thr_low_q  <= (thr_low > thr_high) ? thr_high : thr_low;
         end
         if ((state_q == FLUSH) && in_valid) begin
            err <= 1'b1;
         end
      end
   end

   // line buffers: lb1 holds row r-1, lb2 holds row r-2
   assign pix_in = {dir_in, mag_in};

   nms_line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb1 (
      .clk     (clk),
      .wr_en   (accept),
      .addr    (col_q),
      .wr_data (pix_in),
      .rd_data (lb1_rd)
   );

   nms_line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb2 (
      .clk     (clk),
      .wr_en   (accept),
      .addr    (col_q),
      .wr_data (lb1_rd),
      .rd_data (lb2_rd)
   );

   assign top_e          = lb2_rd[MAG_W-1:0];
   assign mid_e          = lb1_rd[MAG_W-1:0];
   assign bot_e          = mag_in;
   assign unused_top_dir = lb2_rd[PW-1:MAG_W];

   // registered columns c-2 and c-1; the line-buffer/input column is the
   // third tap, which is what lets compare happen in the accept cycle
   always_ff @(posedge clk) begin
      if (accept) begin
         top_w     <= top_c;
         top_c     <= top_e;
         mid_w     <= mid_c;
         mid_c     <= mid_e;
         mid_c_dir <= grad_dir_t'(lb1_rd[PW-1:MAG_W]);
         bot_w     <= bot_c;
         bot_c     <= bot_e;
      end
   end

   // centre is (r-1, c-1). For c = 0 the centre wraps to column IMG_W-1 of
   // the row before; that pixel is a border so the mixed window is ignored.
   assign emit   = (row_q > ROW_ONE) || ((row_q == ROW_ONE) && (col_q != '0));
   assign border = (col_q == '0) || (col_q == COL_ONE) || (row_q == ROW_ONE);

   always_comb begin
      nb_a = mid_w;
      nb_b = mid_e;
      case (mid_c_dir)
         DIR_0:   begin nb_a = mid_w; nb_b = mid_e; end
         DIR_45:  begin nb_a = top_e; nb_b = bot_w; end
         DIR_90:  begin nb_a = top_c; nb_b = bot_c; end
         DIR_135: begin nb_a = top_w; nb_b = bot_e; end
         default: begin nb_a = mid_w; nb_b = mid_e; end
      endcase
   end

   assign keep = (mid_c >= nb_a) && (mid_c >= nb_b);

   // stage 1: window compare
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_eof   <= 1'b0;
         s1_keep  <= 1'b0;
         s1_mag   <= '0;
      end else begin
         s1_valid <= (accept && emit) || flush_issue;
         s1_eof   <= flush_last;
         s1_keep  <= accept && emit && !border && keep;
         s1_mag   <= mid_c;
      end
   end

   // stage 2: classify and register outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_eof    <= 1'b0;
         edge_mag   <= '0;
         edge_class <= EDGE_NONE;
      end else begin
         out_valid <= s1_valid;
         out_eof   <= s1_eof;
         if (s1_keep && (s1_mag >= thr_high_q)) begin
            edge_mag   <= s1_mag;
            edge_class <= EDGE_STRONG;
         end else if (s1_keep && (s1_mag >= thr_low_q)) begin
            edge_mag   <= s1_mag;
            edge_class <= EDGE_WEAK;
         end else begin
            edge_mag   <= '0;
            edge_class <= EDGE_NONE;
         end
      end
   end

endmodule

// File: tb/tb_nms_stream_classifier.sv
// Self-checking bench for nms_stream_classifier on a 5x5 frame.
// A driver issues frames and pushes the expected per-pixel results and
// output cycles into queues; a negedge monitor pops and compares.
module tb_nms_stream_classifier;

   localparam int W  = 5;
   localparam int H  = 5;
   localparam int MW = 11;
   localparam int N  = W * H;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [MW-1:0] mag_in = '0;
   logic [1:0]    dir_in = '0;
   logic          in_valid = 1'b0;
   logic [MW-1:0] thr_low = '0;
   logic [MW-1:0] thr_high = '0;
   logic [MW-1:0] edge_mag;
   logic [1:0]    edge_class;
   logic          out_valid, out_eof, busy, err;

   nms_stream_classifier #(.IMG_W(W), .IMG_H(H), .MAG_W(MW)) dut (
      .clk        (clk),
      .rst        (rst),
      .mag_in     (mag_in),
      .dir_in     (dir_in),
      .in_valid   (in_valid),
      .thr_low    (thr_low),
      .thr_high   (thr_high),
      .edge_mag   (edge_mag),
      .edge_class (edge_class),
      .out_valid  (out_valid),
      .out_eof    (out_eof),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int mag;
      int cls;
      int eof;
   } exp_t;

   exp_t exp_q[$];
   int   cyc_q[$];

   int fr_mag [N];
   int fr_dir [N];
   int f_thr_l, f_thr_h;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int px(int r, int c);
      return fr_mag[r * W + c];
   endfunction

   // reference: classify pixel (r,c) of the current frame from the rules
   function automatic exp_t model(int r, int c);
      exp_t e;
      int m, a, b, lo;
      e.mag = 0;
      e.cls = 0;
      e.eof = (r * W + c == N - 1) ? 1 : 0;
      if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return e;
      m = px(r, c);
      case (fr_dir[r * W + c])
         0:       begin a = px(r, c - 1);     b = px(r, c + 1);     end
         1:       begin a = px(r - 1, c + 1); b = px(r + 1, c - 1); end
         2:       begin a = px(r - 1, c);     b = px(r + 1, c);     end
         default: begin a = px(r - 1, c - 1); b = px(r + 1, c + 1); end
      endcase
      lo = (f_thr_l > f_thr_h) ? f_thr_h : f_thr_l;
      if (m < a || m < b) return e;
      if (m >= f_thr_h) begin
         e.mag = m; e.cls = 2;
      end else if (m >= lo) begin
         e.mag = m; e.cls = 1;
      end
      return e;
   endfunction

   // monitor
   int  frame_cnt = 0;
   bit  eof_seen  = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      int   ec;
      if (rst) begin
         frame_cnt = 0;
         eof_seen  = 1'b0;
      end else begin
         if (eof_seen) begin
            check("busy_fall", int'(busy), 0);
            eof_seen = 1'b0;
         end
         if (out_valid) begin
            frame_cnt++;
            if (exp_q.size() == 0 || cyc_q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               e  = exp_q.pop_front();
               ec = cyc_q.pop_front();
               check("edge_mag", int'(edge_mag), e.mag);
               check("edge_class", int'(edge_class), e.cls);
               check("out_eof", int'(out_eof), e.eof);
               check("out_cycle", cyc, ec);
            end
            if (out_eof) begin
               check("frame_count", frame_cnt, N);
               check("busy_at_eof", int'(busy), 1);
               frame_cnt = 0;
               eof_seen  = 1'b1;
            end
         end
      end
   end

   task automatic do_reset(input int n);
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         mag_in   = MW'($urandom);
         dir_in   = 2'($urandom);
         thr_low  = MW'($urandom);
         thr_high = MW'($urandom);
         @(posedge clk); #1;
         check("rst_out_valid", int'(out_valid), 0);
         check("rst_edge_mag", int'(edge_mag), 0);
         check("rst_edge_class", int'(edge_class), 0);
         check("rst_out_eof", int'(out_eof), 0);
         check("rst_busy", int'(busy), 0);
         check("rst_err", int'(err), 0);
      end
      rst      = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      cyc_q.delete();
   endtask

   // gap_mode: 0 back-to-back, 1 alternate idle cycles, 2 random 0..2 gaps
   task automatic run_frame(input int gap_mode, input int n_pix, input bit poke);
      bit full;
      int gaps;
      bit done;
      full = (n_pix == N);
      if (full) begin
         for (int k = 0; k < N; k++) exp_q.push_back(model(k / W, k % W));
      end
      for (int i = 0; i < n_pix; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         mag_in   = MW'(fr_mag[i]);
         dir_in   = 2'(fr_dir[i]);
         if (i == 0) begin
            thr_low  = MW'(f_thr_l);
            thr_high = MW'(f_thr_h);
         end else begin
            thr_low  = MW'($urandom);
            thr_high = MW'($urandom);
         end
         if (full && i >= W + 1) cyc_q.push_back(cyc + 2);
         if (full && i == N - 1) begin
            for (int j = 0; j <= W; j++) cyc_q.push_back(cyc + 3 + j);
         end
         if (i != n_pix - 1) begin
            gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
               @(posedge clk); #1;
               in_valid = 1'b0;
               mag_in   = MW'($urandom);
            end
         end
      end
      if (!full) return;
      if (poke) begin
         for (int p = 0; p < 3; p++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            mag_in   = MW'($urandom);
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      done = 1'b0;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
      end
      check("busy_timeout", int'(done), 1);
      check("expected_left", exp_q.size(), 0);
   endtask

   task automatic set_uniform(input int m, input int lo, input int hi);
      for (int k = 0; k < N; k++) begin
         fr_mag[k] = m;
         fr_dir[k] = 0;
      end
      f_thr_l = lo;
      f_thr_h = hi;
   endtask

   task automatic set_random();
      for (int k = 0; k < N; k++) begin
         fr_mag[k] = int'($urandom_range(0, 255));
         fr_dir[k] = int'($urandom_range(0, 3));
      end
      f_thr_l = int'($urandom_range(0, 255));
      f_thr_h = int'($urandom_range(0, 255));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset(4);

      set_uniform(100, 50, 80);
      run_frame(0, N, 1'b0);

      for (int k = 0; k < N; k++) begin
         fr_mag[k] = (k % W == 2) ? 200 : 50;
         fr_dir[k] = 0;
      end
      run_frame(0, N, 1'b0);

      set_uniform(60, 50, 80);
      run_frame(0, N, 1'b0);
      set_uniform(40, 50, 80);
      run_frame(0, N, 1'b0);
      set_uniform(85, 90, 80);
      run_frame(0, N, 1'b0);
      check("err_clean", int'(err), 0);

      set_random();
      run_frame(1, N, 1'b1);
      check("err_sticky", int'(err), 1);

      do_reset(3);

      set_uniform(100, 50, 80);
      run_frame(0, 7, 1'b0);
      do_reset(2);
      run_frame(0, N, 1'b0);

      for (int f = 0; f < 3; f++) begin
         set_random();
         run_frame(2, N, 1'b0);
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
